// File: rtl/watch_alarm.sv
// 24-hour clock with keypad time/alarm entry, alarm output and
// a multiplexed 8-digit 7-segment display driver.

module seg_decode (
    input  logic [3:0] digit,
    output logic [7:0] seg
);
    always_comb begin
        seg = 8'h00;
        case (digit)
            4'd0: seg = 8'h3F;
            4'd1: seg = 8'h06;
            4'd2: seg = 8'h5B;
            4'd3: seg = 8'h4F;
            4'd4: seg = 8'h66;
            4'd5: seg = 8'h6D;
            4'd6: seg = 8'h7D;
            4'd7: seg = 8'h07;
            4'd8: seg = 8'h7F;
            4'd9: seg = 8'h6F;
            default: seg = 8'h00;
        endcase
    end
endmodule

module watch_alarm #(
    parameter int CLK_HZ    = 1000,
    parameter int SCAN_DIV  = 1,
    parameter int ALARM_SEC = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       alarm_en,
    input  logic [9:0] keypad,
    output logic [7:0] seg_data,
    output logic [7:0] seg_com,
    output logic       alarm_out,
    output logic       key_err,
    output logic       time_valid
);
    localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX   = TW'(CLK_HZ - 1);
    localparam logic [TW-1:0] BLINK_HALF = TW'(CLK_HZ / 2);
    localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);
    localparam logic [7:0]    RING_MAX   = 8'(ALARM_SEC - 1);
    localparam logic [1:0]    M_TIME     = 2'b01;
    localparam logic [1:0]    M_ALARM    = 2'b10;

    // Digit index equals edit position: 0 = h_ten ... 5 = s_one.
    logic [5:0][3:0] tim, alm, tnext, tgt, wr, src;
    logic [9:0]      key_prev;
    logic [1:0]      mode_prev;
    logic [2:0]      ptr, pos, slot;
    logic [TW-1:0]   tick, blink;
    logic [SW-1:0]   div;
    logic [7:0]      ring;
    logic [3:0]      digit, lim;
    logic [7:0]      pat [6];
    logic alarm_valid, step_q;
    logic key_ev, mode_chg, edit_t, edit_a, edit;
    logic accept, reject, run_en, wrap, match, clear, blank;

    assign key_ev = (keypad != 10'd0)
                 && ((keypad & (keypad - 10'd1)) == 10'd0)
                 && (key_prev == 10'd0);
    assign mode_chg = (mode != mode_prev);
    assign pos      = mode_chg ? 3'd0 : ptr;
    assign edit_t   = (mode == M_TIME);
    assign edit_a   = (mode == M_ALARM);
    assign edit     = edit_t | edit_a;
    assign tgt      = edit_a ? alm : tim;
    assign accept   = key_ev && edit && (digit <= lim);
    assign reject   = key_ev && edit && (digit > lim);
    assign run_en   = time_valid && !edit_t;
    assign wrap     = run_en && (tick == TICK_MAX);
    assign match    = step_q && alarm_en && time_valid
                   && alarm_valid && !edit_t && (tim == alm);
    assign clear    = key_ev || !alarm_en || edit_t;

    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 10; i++)
            if (keypad[i]) digit = 4'(i);
    end

    always_comb begin
        lim = 4'd9;
        unique case (1'b1)
            (pos == 3'd0): lim = 4'd2;
            (pos == 3'd1): lim = (tgt[0] == 4'd2) ? 4'd3 : 4'd9;
            (pos == 3'd2): lim = 4'd5;
            (pos == 3'd4): lim = 4'd5;
            default:       lim = 4'd9;
        endcase
    end

    always_comb begin
        wr = tgt;
        wr[pos] = digit;
        if (pos == 3'd0 && digit == 4'd2 && tgt[1] > 4'd3)
            wr[1] = 4'd0;
    end

    always_comb begin
        tnext = tim;
        if (tim[5] != 4'd9) tnext[5] = tim[5] + 4'd1;
        else begin
            tnext[5] = 4'd0;
            if (tim[4] != 4'd5) tnext[4] = tim[4] + 4'd1;
            else begin
                tnext[4] = 4'd0;
                if (tim[3] != 4'd9) tnext[3] = tim[3] + 4'd1;
                else begin
                    tnext[3] = 4'd0;
                    if (tim[2] != 4'd5) tnext[2] = tim[2] + 4'd1;
                    else begin
                        tnext[2] = 4'd0;
                        if (tim[0] == 4'd2 && tim[1] == 4'd3) begin
                            tnext[0] = 4'd0;
                            tnext[1] = 4'd0;
                        end else if (tim[1] == 4'd9) begin
                            tnext[1] = 4'd0;
                            tnext[0] = tim[0] + 4'd1;
                        end else begin
                            tnext[1] = tim[1] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tim         <= '0;
            alm         <= '0;
            key_prev    <= '0;
            mode_prev   <= '0;
            ptr         <= '0;
            tick        <= '0;
            blink       <= '0;
            ring        <= '0;
            alarm_valid <= 1'b0;
            step_q      <= 1'b0;
            time_valid  <= 1'b0;
            alarm_out   <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            key_prev  <= keypad;
            mode_prev <= mode;
            key_err   <= reject;
            step_q    <= wrap;
            blink     <= (blink == TICK_MAX) ? '0 : blink + TW'(1);
            if (edit_t) tick <= '0;
            else if (run_en) tick <= wrap ? '0 : tick + TW'(1);
            if (accept) ptr <= (pos == 3'd5) ? 3'd0 : pos + 3'd1;
            else if (mode_chg) ptr <= 3'd0;
            if (accept && edit_t) begin
                tim        <= wr;
                time_valid <= (pos == 3'd5);
            end else if (wrap) begin
                tim <= tnext;
            end
            if (accept && edit_a) begin
                alm         <= wr;
                alarm_valid <= (pos == 3'd5);
            end
            // Any clear condition wins over a fresh match.
            if (clear) alarm_out <= 1'b0;
            else if (match) begin
                alarm_out <= 1'b1;
                ring      <= '0;
            end else if (alarm_out && wrap) begin
                if (ring == RING_MAX) alarm_out <= 1'b0;
                else ring <= ring + 8'd1;
            end
        end
    end

    assign src = edit_a ? alm : tim;

    for (genvar g = 0; g < 6; g++) begin : g_dec
        seg_decode u_dec (.digit(src[g]), .seg(pat[g]));
    end

    assign blank = edit && (slot == ptr) && (blink >= BLINK_HALF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            slot     <= '0;
            seg_com  <= 8'hFF;
            seg_data <= 8'h00;
        end else begin
            if (div == SCAN_MAX) begin
                div  <= '0;
                slot <= slot + 3'd1;
            end else begin
                div <= div + SW'(1);
            end
            case (slot)
                3'd0:    seg_com <= 8'h7F;
                3'd1:    seg_com <= 8'hBF;
                3'd2:    seg_com <= 8'hDF;
                3'd3:    seg_com <= 8'hEF;
                3'd4:    seg_com <= 8'hF7;
                3'd5:    seg_com <= 8'hFB;
                default: seg_com <= 8'hFF;
            endcase
            if (slot > 3'd5 || blank) seg_data <= 8'h00;
            else seg_data <= pat[slot];
        end
    end
endmodule

// File: doc/watch_alarm.md
# watch_alarm

Parametrised next-generation digital clock core for the FPGA training board. It counts HH:MM:SS in 24-hour format and takes keypad entry for both time and a separate alarm time, with per-digit range validation. It drives the 8-digit multiplexed 7-segment display, blinking the digit being edited, and raises an alarm output on a time match. Segment patterns come from the team's existing `seg_decode` block, one instance per displayed digit.

## Interface
Parameters:
- `CLK_HZ`, 1000: input clock frequency; one second equals `CLK_HZ` cycles (minimum 4).
- `SCAN_DIV`, 1: clocks each display slot is held before the scan advances (minimum 1).
- `ALARM_SEC`, 30: number of seconds `alarm_out` stays high once triggered (1..255).

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `mode` input 2: 00/11 = run, 01 = set time, 10 = set alarm.
- `alarm_en` input 1: 1 = alarm armed.
- `keypad` input 10: one-hot digit keys; bit n means digit n.
- `seg_data` output 8: segment pattern of the current scan slot.
- `seg_com` output 8: active-low digit select.
- `alarm_out` output 1: alarm ringing.
- `key_err` output 1: one-cycle pulse when a key is rejected.
- `time_valid` output 1: a full time has been entered and the clock is running.

## Operation
- **Reset values:**
  - All time and alarm digits = 0; tick counter = 0.
  - Edit pointer = 0; scan counter = 0; internal `alarm_valid` = 0.
  - `time_valid` = 0, `alarm_out` = 0, `key_err` = 0.
  - `seg_com` = 8'hFF, `seg_data` = 8'h00.
- **Key event:** `keypad` is nonzero and exactly one-hot while the previous-cycle sample was zero. Any non-one-hot nonzero value is ignored; no `key_err` is raised.
- **Edit pointer:** values 0..5 map to h_ten, h_one, m_ten, m_one, s_ten, s_one. The pointer resets to 0 on any change of `mode`.
- **Digit validation, by position:**
  - 0: ≤ 2.
  - 1: ≤ 9, or ≤ 3 when h_ten = 2.
  - 2: ≤ 5.
  - 3: ≤ 9.
  - 4: ≤ 5.
  - 5: ≤ 9.
- **Rejected digit:** pulse `key_err`, leave the register and pointer unchanged.
- **Accepted digit:** write it to the target set (time in mode 01, alarm in mode 10), then advance the pointer, wrapping 5 → 0.
- **h_ten = 2 clamp:** writing 2 at position 0 while h_one > 3 forces h_one to 0 in the same cycle.
- **Set time (01):**
  - The tick counter is held at 0 and the time does not count.
  - The first accepted digit clears `time_valid`; the digit at position 5 sets it.
- **Set alarm (10):**
  - The time keeps counting if `time_valid` = 1.
  - Alarm entry clears and sets `alarm_valid` the same way entry clears and sets `time_valid`.
- **Run (00/11):**
  - Counting happens only while `time_valid` = 1. The tick counter runs 0..`CLK_HZ`-1.
  - At `CLK_HZ`-1 the counter returns to 0 and the seconds increment with BCD carries: s 9→0, s_ten 5→0, m 9→0, m_ten 5→0.
  - Hours roll 23 → 00, and h_one 9 → 0 carries into h_ten.
- **Alarm trigger:** all of the following must hold:
  - `alarm_en` = 1, `time_valid` = 1, `alarm_valid` = 1, and `mode` ≠ 01.
  - A seconds increment has just made the time equal to the alarm.
  - Setting the time to equal the alarm does not trigger.
- **Alarm clear:** `alarm_out` is cleared after `ALARM_SEC` further seconds, on any key event, on `alarm_en` falling to 0, or on entering mode 01.
- **Display:**
  - A 3-bit scan counter advances every `SCAN_DIV` clocks.
  - Slots 0..5 select h_ten..s_one with `seg_com` 7F, BF, DF, EF, F7, FB. Slots 6..7 drive `seg_com` = FF and `seg_data` = 00.
  - The source is the alarm digits in mode 10 and the time digits otherwise.
- **Blink:** in modes 01/10, the slot equal to the edit pointer shows `seg_data` = 00 while a blink phase counter (a free-running 0..`CLK_HZ`-1 counter, separate from the frozen tick counter) is ≥ `CLK_HZ`/2.

## Timing
- Key accept: the register updates at the clock edge after the rising key is sampled. `key_err` is high for exactly that one cycle.
- Second update: on the edge where the tick counter wraps, giving exactly `CLK_HZ` cycles per increment in steady run.
- `alarm_out` rises one cycle after the matching time appears in the registers.
- `seg_com` and `seg_data` are registered: each reflects the scan slot selected on the previous cycle. A digit change is visible within 8·`SCAN_DIV`+1 cycles.
- Simultaneous events:
  - A key event during ringing clears the alarm and is also processed as an entry in modes 01/10.
  - A tick and an alarm match in the same cycle count and trigger together.
  - A mode change and a key in the same cycle: the pointer resets to 0 and the key is applied at position 0 under the new mode.
- `rst` mid-operation forces all reset values immediately, without waiting for `clk`.

## Test plan
- Mode 01, keys 2,3,5,9,5,8, then mode 00 → `time_valid` = 1; after 2·`CLK_HZ` cycles the time reads 23:59:58 → 00:00:00.
- Mode 01, key 3 at position 0 → `key_err` pulses once, h_ten stays 0, pointer stays 0. Key 2 with h_one = 7 → h_ten = 2, h_one = 0.
- Alarm set to 00:00:05, time 00:00:00, `alarm_en` = 1 → `alarm_out` rises 1 cycle after the time reaches 00:00:05 and falls after `ALARM_SEC` seconds.
- Alarm ringing, then a key press → `alarm_out` = 0 the next cycle and the time is unchanged in mode 00.
- `SCAN_DIV` = 2 → `seg_com` cycles 7F, BF, DF, EF, F7, FB, FF, FF, each held 2 cycles. In mode 01 with pointer 3, `seg_data` = 00 in slot 3 during the second half-second.
- Assert `rst` mid-count at 12:34:56 → all outputs return to their reset values asynchronously, and counting stays stopped until a new time is entered.
